// File: rtl/hex_lexer_pkg.sv
// Shared constants for the hex word lexer: ASCII codes, lexer states, error bit positions
// and a digit decoder.
package hex_lexer_pkg;

  localparam logic [7:0] ChTab   = 8'h09;
  localparam logic [7:0] ChLf    = 8'h0A;
  localparam logic [7:0] ChCr    = 8'h0D;
  localparam logic [7:0] ChSpace = 8'h20;
  localparam logic [7:0] ChHash  = 8'h23;

  localparam logic [0:0] StScan    = 1'b0;
  localparam logic [0:0] StComment = 1'b1;

  localparam int unsigned ErrOverflow  = 0;
  localparam int unsigned ErrUnderflow = 1;
  localparam int unsigned ErrBadChar   = 2;

  typedef struct packed {
    logic       valid;
    logic [3:0] value;
  } hex_digit_t;

  function automatic hex_digit_t hex_decode(input logic [7:0] ch);
    hex_digit_t d;
    d.valid = 1'b0;
    d.value = 4'h0;
    if (ch >= 8'h30 && ch <= 8'h39) begin
      d.valid = 1'b1;
      d.value = ch[3:0];
    end else if ((ch >= 8'h41 && ch <= 8'h46) || (ch >= 8'h61 && ch <= 8'h66)) begin
      // Low nibble of 'A'/'a' is 1, so adding 9 yields 10..15.
      d.valid = 1'b1;
      d.value = 4'(ch[3:0] + 4'd9);
    end
    return d;
  endfunction

  function automatic logic is_blank(input logic [7:0] ch);
    return (ch == ChSpace) || (ch == ChTab) || (ch == ChCr) || (ch == ChLf);
  endfunction

endpackage

// File: rtl/fifo.sv
// First-word fall-through FIFO with overflow/underflow pulses; a pop while full makes
// room for a same-cycle push.
module fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] data_out,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign empty    = (count_q == '0);
  assign full     = (count_q == (AW + 1)'(DEPTH));
  assign data_out = empty ? '0 : mem_q[rd_ptr_q];

  // An illegal pop freezes the FIFO entirely, including any same-cycle push.
  assign underflow = pop && empty;
  assign overflow  = push && full && !pop;
  assign do_pop    = pop && !empty;
  assign do_push   = push && !underflow && !overflow;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      count_q <= count_q + 1'b1;
      else if (do_pop && !do_push) count_q <= count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/hex_word_lexer.sv
// Lexes an ASCII stream of hex digits, blanks and '#' comments into fixed-width words
// and queues them in a FIFO with sticky error flags.
module hex_word_lexer
  import hex_lexer_pkg::*;
#(
  parameter int WORD_BYTES = 1,
  parameter int DEPTH      = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push_back,
  input  logic [7:0]              data_in,
  input  logic                    pop_front,
  output logic [8*WORD_BYTES-1:0] data_out,
  output logic                    empty,
  output logic                    full,
  output logic [2:0]              error
);

  localparam int W      = 8 * WORD_BYTES;
  localparam int Digits = 2 * WORD_BYTES;
  localparam int CntW   = $clog2(Digits);

  logic [0:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [W-1:0]    word_q, word_d;
  logic            push_q, push_d;
  logic [W-1:0]    push_word_q, push_word_d;
  logic [2:0]      error_q;
  logic            bad_char, overflow, underflow;
  hex_digit_t      hv;
  logic [W-1:0]    shifted;

  assign hv      = hex_decode(data_in);
  assign shifted = (word_q << 4) | W'(hv.value);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    word_d      = word_q;
    push_d      = 1'b0;
    push_word_d = push_word_q;
    bad_char    = 1'b0;
    if (push_back) begin
      unique case (state_q)
        StScan: begin
          if (is_blank(data_in)) begin
            state_d = StScan;
          end else if (data_in == ChHash) begin
            state_d = StComment;
          end else if (hv.valid) begin
            if (cnt_q == CntW'(Digits - 1)) begin
              push_d      = 1'b1;
              push_word_d = shifted;
              cnt_d       = '0;
              word_d      = '0;
            end else begin
              cnt_d  = cnt_q + 1'b1;
              word_d = shifted;
            end
          end else begin
            bad_char = 1'b1;
          end
        end
        StComment: begin
          if (data_in == ChLf) state_d = StScan;
        end
        default: state_d = StScan;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StScan;
      cnt_q       <= '0;
      word_q      <= '0;
      push_q      <= 1'b0;
      push_word_q <= '0;
      error_q     <= 3'b000;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      word_q      <= word_d;
      push_q      <= push_d;
      push_word_q <= push_word_d;
      error_q[ErrBadChar]   <= error_q[ErrBadChar] | bad_char;
      error_q[ErrUnderflow] <= error_q[ErrUnderflow] | underflow;
      error_q[ErrOverflow]  <= error_q[ErrOverflow] | overflow;
    end
  end

  assign error = error_q;

  fifo #(
    .WIDTH(W),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push_q),
    .push_data(push_word_q),
    .pop      (pop_front),
    .data_out (data_out),
    .empty    (empty),
    .full     (full),
    .overflow (overflow),
    .underflow(underflow)
  );

endmodule

// File: tb/tb_hex_word_lexer.sv
// Directed bench for hex_word_lexer with 16-bit words and a 4-deep FIFO.
module tb_hex_word_lexer;

  logic        clk = 1'b0;
  logic        rst;
  logic        push_back;
  logic [7:0]  data_in;
  logic        pop_front;
  logic [15:0] data_out;
  logic        empty, full;
  logic [2:0]  error;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  hex_word_lexer #(
    .WORD_BYTES(2),
    .DEPTH(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .push_back(push_back),
    .data_in  (data_in),
    .pop_front(pop_front),
    .data_out (data_out),
    .empty    (empty),
    .full     (full),
    .error    (error)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) begin
      @(negedge clk);
      push_back = 1'b1;
      data_in   = s[i];
      @(posedge clk);
      #1 push_back = 1'b0;
    end
  endtask

  // One more edge lets the registered push land, then sample on the falling edge.
  task automatic settle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pop_one();
    @(negedge clk);
    pop_front = 1'b1;
    @(posedge clk);
    #1 pop_front = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst       = 1'b1;
    push_back = 1'b0;
    data_in   = 8'h00;
    pop_front = 1'b0;
    repeat (2) @(posedge clk);
    do_reset();
    chk("reset_empty", 32'(empty), 32'd1);
    chk("reset_full", 32'(full), 32'd0);
    chk("reset_error", 32'(error), 32'd0);
    chk("reset_data", 32'(data_out), 32'd0);

    send_str("12 ab");
    settle();
    chk("t1_empty", 32'(empty), 32'd0);
    chk("t1_data", 32'(data_out), 32'h12AB);
    chk("t1_error", 32'(error), 32'd0);
    pop_one();
    chk("t1_drained", 32'(empty), 32'd1);

    send_str("1# zz9\n2A3");
    settle();
    chk("t2_data", 32'(data_out), 32'h12A3);
    chk("t2_error", 32'(error), 32'd0);
    pop_one();
    chk("t2_drained", 32'(empty), 32'd1);

    send_str("12g34");
    settle();
    chk("t3_data", 32'(data_out), 32'h1234);
    chk("t3_error", 32'(error), 32'b100);
    pop_one();
    do_reset();
    chk("t3_error_cleared", 32'(error), 32'd0);

    send_str("000100020003");
    settle();
    chk("t4_not_full_at_3", 32'(full), 32'd0);
    send_str("0004");
    settle();
    chk("t4_full_at_4", 32'(full), 32'd1);
    chk("t4_no_err_at_4", 32'(error), 32'd0);
    send_str("0005");
    settle();
    chk("t4_overflow_err", 32'(error), 32'b001);
    chk("t4_still_full", 32'(full), 32'd1);
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("t4_pop%0d", i), 32'(data_out), 32'(i));
      pop_one();
    end
    chk("t4_drained", 32'(empty), 32'd1);

    do_reset();
    pop_one();
    chk("t5_underflow_err", 32'(error), 32'b010);
    chk("t5_still_empty", 32'(empty), 32'd1);
    do_reset();
    chk("t5_err_after_rst", 32'(error), 32'd0);
    chk("t5_empty_after_rst", 32'(empty), 32'd1);

    send_str("123");
    do_reset();
    send_str("4567");
    settle();
    chk("t6_data", 32'(data_out), 32'h4567);
    pop_one();
    chk("t6_single_word", 32'(empty), 32'd1);
    chk("t6_error", 32'(error), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
